// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencing controller.
// The state encoding is 2 bits wide so it can be probed directly by the CORDIC top level.
package cordic_pkg;

  localparam int CW            = 6;
  localparam int NITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Host-side handshake bundle: operand accept (in_*) and result delivery (out_*).
interface cordic_seq_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);

endinterface

// File: rtl/cordic_seq_ctrl.sv
// Control FSM that sequences one CORDIC rotation per accepted host request.
// Every output is decoded from the state register and shadow counter, never from an input.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int NITER = NITER_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  cordic_seq_ctrl_if.slave  host,
  input  logic              abort,
  input  logic [CW-1:0]     iter_count,
  output logic              cnt_start,
  output logic              load,
  output logic              iter_en,
  output logic              last_iter,
  output logic              busy,
  output logic              cnt_err
);

  localparam logic [CW-1:0] LAST_CNT = CW'(NITER - 1);

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] shadowCnt;
  logic [CW-1:0] nextShadow;

  // State, shadow count and the sticky counter-disagreement flag; only reset clears cnt_err.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadowCnt <= '0;
      cnt_err   <= 1'b0;
    end else begin
      state     <= nextState;
      shadowCnt <= nextShadow;
      if (state == RUN && iter_count != shadowCnt) begin
        cnt_err <= 1'b1;
      end
    end
  end

  // Next-state logic: abort wins everywhere except IDLE, where a new accept takes precedence.
  always_comb begin
    nextState  = state;
    nextShadow = shadowCnt;
    case (state)
      IDLE: begin
        if (host.in_valid) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        nextState = abort ? IDLE : RUN;
      end
      RUN: begin
        nextShadow = shadowCnt + CW'(1);
        if (abort) begin
          nextState = IDLE;
        end else if (shadowCnt == LAST_CNT) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (abort || host.out_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (nextState == IDLE || nextState == LOAD) begin
      nextShadow = '0;
    end
  end

  // The iteration counter is held at zero whenever it is not being stepped by RUN.
  always_comb begin
    host.in_ready  = (state == IDLE);
    host.out_valid = (state == DONE);
    cnt_start      = (state != RUN);
    load           = (state == LOAD);
    iter_en        = (state == RUN);
    last_iter      = (state == RUN) && (shadowCnt == LAST_CNT);
    busy           = (state == LOAD) || (state == RUN);
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench: a table-driven sweep on an NITER=1 build plus directed
// multi-cycle sequences (timing, back-pressure, abort, counter fault, reset) on an NITER=32 build.
module tb_cordic_seq_ctrl;

  import cordic_pkg::*;

  // Packed output order: {in_ready, out_valid, cnt_start, load, iter_en, last_iter, busy, cnt_err}
  localparam logic [7:0] IDLEV = 8'b1010_0000;
  localparam logic [7:0] LOADV = 8'b0011_0010;
  localparam logic [7:0] RUNV  = 8'b0000_1010;
  localparam logic [7:0] LASTV = 8'b0000_1110;
  localparam logic [7:0] DONEV = 8'b0110_0000;

  typedef struct {
    string      name;
    logic       inValid;
    logic       outReady;
    logic       abortIn;
    logic [7:0] expOut;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  cordic_seq_ctrl_if ifA ();
  cordic_seq_ctrl_if ifB ();

  logic          abortA, cntStartA, loadA, iterEnA, lastA, busyA, errA, faultA, errExpA;
  logic [CW-1:0] cntModelA, iterCountA;
  logic          abortB, cntStartB, loadB, iterEnB, lastB, busyB, errB;
  logic [CW-1:0] cntModelB;

  cordic_seq_ctrl #(.NITER(32)) dutA (
    .clock(clock), .reset(reset), .host(ifA), .abort(abortA), .iter_count(iterCountA),
    .cnt_start(cntStartA), .load(loadA), .iter_en(iterEnA), .last_iter(lastA),
    .busy(busyA), .cnt_err(errA)
  );

  cordic_seq_ctrl #(.NITER(1)) dutB (
    .clock(clock), .reset(reset), .host(ifB), .abort(abortB), .iter_count(cntModelB),
    .cnt_start(cntStartB), .load(loadB), .iter_en(iterEnB), .last_iter(lastB),
    .busy(busyB), .cnt_err(errB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural iteration counters; faultA forces a wrong count into dutA.
  always @(posedge clock) begin
    if (cntStartA) cntModelA <= '0;
    else           cntModelA <= cntModelA + 1'b1;
    if (cntStartB) cntModelB <= '0;
    else           cntModelB <= cntModelB + 1'b1;
  end
  assign iterCountA = faultA ? 6'd7 : cntModelA;

  function automatic logic [7:0] packA();
    return {ifA.in_ready, ifA.out_valid, cntStartA, loadA, iterEnA, lastA, busyA, errA};
  endfunction

  function automatic logic [7:0] packB();
    return {ifB.in_ready, ifB.out_valid, cntStartB, loadB, iterEnB, lastB, busyB, errB};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %b want %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifB.in_valid  = v.inValid;
    ifB.out_ready = v.outReady;
    abortB        = v.abortIn;
  endtask

  // One NITER=32 op on dutA from IDLE; abortAt/faultAt select a RUN iteration (-1 = none).
  task automatic runOpA(input int abortAt, input int faultAt);
    ifA.in_valid = 1'b1;
    @(negedge clock);
    ifA.in_valid = 1'b0;
    checkOutput("A load", packA(), LOADV | {7'b0, errExpA});
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      checkOutput($sformatf("A run %0d", i), packA(), ((i == 31) ? LASTV : RUNV) | {7'b0, errExpA});
      checkOutput($sformatf("A count %0d", i), {2'b00, cntModelA}, 8'(i));
      faultA = (i == faultAt);
      if (i == faultAt) errExpA = 1'b1;
      if (i == abortAt) begin
        abortA = 1'b1;
        @(negedge clock);
        abortA = 1'b0;
        checkOutput("A abort idle", packA(), IDLEV | {7'b0, errExpA});
        return;
      end
    end
    @(negedge clock);
    faultA = 1'b0;
    checkOutput("A done", packA(), DONEV | {7'b0, errExpA});
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{"B idle accept",      1'b1, 1'b0, 1'b0, IDLEV};
    vecs[1]  = '{"B load",             1'b0, 1'b0, 1'b0, LOADV};
    vecs[2]  = '{"B single run",       1'b0, 1'b0, 1'b0, LASTV};
    vecs[3]  = '{"B done held",        1'b0, 1'b0, 1'b0, DONEV};
    vecs[4]  = '{"B done release",     1'b0, 1'b1, 1'b0, DONEV};
    vecs[5]  = '{"B idle accept 2",    1'b1, 1'b0, 1'b0, IDLEV};
    vecs[6]  = '{"B load abort",       1'b0, 1'b0, 1'b1, LOADV};
    vecs[7]  = '{"B accept beats abort", 1'b1, 1'b0, 1'b1, IDLEV};
    vecs[8]  = '{"B load 3",           1'b0, 1'b0, 1'b0, LOADV};
    vecs[9]  = '{"B run abort",        1'b0, 1'b0, 1'b1, LASTV};
    vecs[10] = '{"B idle abort noop",  1'b0, 1'b0, 1'b1, IDLEV};
    vecs[11] = '{"B idle accept 4",    1'b1, 1'b0, 1'b0, IDLEV};
    vecs[12] = '{"B load 4",           1'b0, 1'b0, 1'b0, LOADV};
    vecs[13] = '{"B run 4",            1'b0, 1'b1, 1'b0, LASTV};
    vecs[14] = '{"B done abort",       1'b0, 1'b0, 1'b1, DONEV};
    vecs[15] = '{"B idle final",       1'b0, 1'b0, 1'b0, IDLEV};

    checks = 0;
    errors = 0;
    reset = 1'b1;
    ifA.in_valid = 1'b0; ifA.out_ready = 1'b1; abortA = 1'b0; faultA = 1'b0; errExpA = 1'b0;
    ifB.in_valid = 1'b0; ifB.out_ready = 1'b0; abortB = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("A reset", packA(), IDLEV);
    checkOutput("B reset", packB(), IDLEV);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      checkOutput(vecs[i].name, packB(), vecs[i].expOut);
      applyStimulus(vecs[i]);
      @(negedge clock);
    end
    ifB.in_valid = 1'b0; ifB.out_ready = 1'b0; abortB = 1'b0;

    // Single op with immediate consume.
    runOpA(-1, -1);
    @(negedge clock);
    checkOutput("A idle after op", packA(), IDLEV);

    // Back-pressure for 10 cycles.
    ifA.out_ready = 1'b0;
    runOpA(-1, -1);
    repeat (10) begin
      @(negedge clock);
      checkOutput("A backpressure", packA(), DONEV);
    end
    ifA.out_ready = 1'b1;
    @(negedge clock);
    checkOutput("A idle after release", packA(), IDLEV);

    // Abort at iteration 5, then a clean op.
    runOpA(5, -1);
    repeat (3) begin
      @(negedge clock);
      checkOutput("A idle after abort", packA(), IDLEV);
    end
    runOpA(-1, -1);
    @(negedge clock);
    checkOutput("A idle post abort op", packA(), IDLEV);

    // Counter fault at shadow 6; flag persists through a later clean op.
    runOpA(-1, 6);
    @(negedge clock);
    checkOutput("A idle with err", packA(), IDLEV | 8'h01);
    runOpA(-1, -1);
    @(negedge clock);
    checkOutput("A err sticky", packA(), IDLEV | 8'h01);

    // Reset while a result is pending.
    ifA.out_ready = 1'b0;
    runOpA(-1, -1);
    reset = 1'b1;
    @(negedge clock);
    errExpA = 1'b0;
    checkOutput("A reset mid done", packA(), IDLEV);
    reset = 1'b0;
    ifA.out_ready = 1'b1;
    @(negedge clock);
    checkOutput("A idle after reset", packA(), IDLEV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
